digi_ota_array: RTL
===================

// Module: digi_ota_array
// PURPOSE
//  Clocked, parametrised successor of the gate-level digital OTA comparator.
//  Provides CH independent channels comparing digital inputs vip/vin.
//  Each channel has input synchronisers, a glitch filter or an integrating
//  up/down accumulator with hysteresis, and a three-state decision FSM.
//  Each output has a valid/enable flag, which replaces the old bufif1 drive.
//  Sits between the ui_in pad inputs and the uo_out/uio_oe pads of the tile.
// PARAMETERS
//  CH    4  number of comparator channels (1..8)
//  FILT  3  consecutive agreeing cycles needed for a decision in mode 0 (>=1)
//  CW    6  accumulator width, signed two's complement (3..16)
//  HYST  4  mode-1 hysteresis threshold magnitude (1 .. 2^(CW-1)-1)
// PORTS
//  clk      in   1          single clock, rising edge
//  rst_n    in   1          asynchronous active-low reset
//  ena      in   1          1 = run; 0 = freeze all state, outputs hold
//  mode     in   1          0 = filtered comparator, 1 = integrating comparator
//  vip      in   CH         non-inverting inputs, asynchronous
//  vin      in   CH         inverting inputs, asynchronous
//  sel      in   clog2(CH)  channel select for acc_out (max(1,..) bits)
//  out      out  CH         decision per channel (1 = vip dominates)
//  out_oe   out  CH         1 = out[i] holds a valid decision; 0 = undefined
//  acc_out  out  CW         registered accumulator of channel sel
// BEHAVIOUR
//  Reset: all sync FFs 0, filt_cnt 0, acc 0, FSM UNDEF, out 0, out_oe 0,
//  acc_out 0. The mode register resets to 0.
//  Sync: vip/vin each pass two FFs giving vip_s/vin_s. All later logic uses
//  only the synchronised values.
//  Diff per channel: UP = vip_s&~vin_s; DN = ~vip_s&vin_s; HOLD otherwise.
//  HOLD is the case where both inputs are equal.
//  FSM per channel: states UNDEF, HIGH, LOW.
//   out = (state==HIGH); out_oe = (state!=UNDEF). Both are registered.
//  Mode 0, filter:
//   filt_cnt counts consecutive cycles of the same non-HOLD diff.
//   filt_cnt reloads to 1 when the diff changes direction.
//   filt_cnt clears to 0 on HOLD. The FSM state holds on HOLD.
//   When a count of FILT is reached on UP: state -> HIGH, from any state.
//   When a count of FILT is reached on DN: state -> LOW, from any state.
//   filt_cnt saturates at FILT.
//   Latency: out changes on the (FILT+2)th rising edge, counting the first
//   edge that samples the new input level. With FILT=1 that is 3 edges.
//  Mode 1, integrate:
//   acc += 1 on UP and acc -= 1 on DN. acc is unchanged on HOLD.
//   acc saturates at +(2^(CW-1)-1) and at -2^(CW-1). It never wraps.
//   When acc >= +HYST after the update: state -> HIGH.
//   When acc <= -HYST after the update: state -> LOW.
//   Otherwise the state holds, including UNDEF.
//   The state update uses the same-cycle next acc value, so acc and state
//   change on the same edge.
//  Mode change: mode is registered. In the cycle mode_q differs from mode,
//  all channels get filt_cnt = 0, acc = 0 and state UNDEF (out_oe = 0).
//  This clear takes priority over a same-cycle decision.
//  ena = 0: sync FFs keep shifting; filt_cnt, acc, FSM, mode_q and acc_out
//  all hold. On return to ena = 1, operation resumes from the held state.
//  acc_out: acc_out <= acc[sel] each enabled cycle (1-cycle latency).
//  In mode 0, acc_out reads 0. A sel value >= CH reads 0.
//  Async reset asserted mid-operation clears everything immediately.
//  After deassertion the first decision again needs the full latency.
//  Channels are fully independent. No cross-channel arbitration.
// TESTING
//  T1 reset: hold rst_n=0, toggle inputs -> out=0, out_oe=0, acc_out=0.
//     Deassert -> all remain 0 until a decision is reached.
//  T2 mode0 FILT=3: ch0 vip=1, vin=0 from edge k.
//     -> out[0]=1 and out_oe[0]=1 after edge k+4, not before.
//  T3 mode0 glitch: ch1 in LOW, apply a 2-cycle UP pulse then DN.
//     -> out[1] stays 0 and out_oe[1] stays 1.
//  T4 mode1 CW=6 HYST=4: 4 UP cycles -> acc_out=4, out=1.
//     Then 7 DN cycles -> acc=-3 and out stays 1. One more DN -> acc=-4, out=0.
//  T5 saturation: 40 UP cycles in mode1 -> acc_out=31, not -32.
//     Then HOLD 10 cycles -> acc_out stays 31.
//  T6 mode/ena: toggle mode with out_oe=1 -> out_oe=0 for all channels.
//     Separately, ena=0 for 5 cycles with UP applied -> acc_out and out unchanged.

Source files
------------

// File: rtl/digi_ota_array_if.sv
// digi_ota_array_if: pad-side bus of the comparator array (inputs, decisions, readback)
interface digi_ota_array_if #(
  parameter int CH = 4,
  parameter int CW = 6
) ();
  localparam int SW = CH > 1 ? $clog2(CH) : 1;
  logic ena;
  logic mode;
  logic [CH-1:0] vip;
  logic [CH-1:0] vin;
  logic [SW-1:0] sel;
  logic [CH-1:0] out;
  logic [CH-1:0] out_oe;
  logic signed [CW-1:0] acc_out;
  modport master (output ena, mode, vip, vin, sel, input out, out_oe, acc_out);
  modport slave (input ena, mode, vip, vin, sel, output out, out_oe, acc_out);
endinterface

// File: rtl/digi_ota_array.sv
// digi_ota_array: CH-channel clocked comparator with glitch filter or integrating decision
module digi_ota_array #(
  parameter int CH = 4,
  parameter int FILT = 3,
  parameter int CW = 6,
  parameter int HYST = 4
) (
  input logic clk,
  input logic rst_n,
  digi_ota_array_if.slave bus
);
  localparam int FW = $clog2(FILT + 1);
  localparam logic signed [CW-1:0] AMAX = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [CW-1:0] AMIN = {1'b1, {(CW-1){1'b0}}};
  localparam logic signed [CW-1:0] HYP = CW'(HYST);
  localparam logic signed [CW-1:0] HYN = -HYP;
  typedef enum logic [1:0] {UNDEF, HIGH, LOW} state_t;
  logic [CH-1:0] vip_m_q, vip_s_q, vin_m_q, vin_s_q;
  logic mode_q, clr;
  logic signed [CW-1:0] acc_all [CH];
  logic signed [CW-1:0] acc_out_q;
  assign clr = bus.mode != mode_q;
  assign bus.acc_out = acc_out_q;
  // synchronisers always shift; mode register and accumulator readback freeze with ena
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vip_m_q <= '0;
      vip_s_q <= '0;
      vin_m_q <= '0;
      vin_s_q <= '0;
      mode_q <= 1'b0;
      acc_out_q <= '0;
    end else begin
      vip_m_q <= bus.vip;
      vip_s_q <= vip_m_q;
      vin_m_q <= bus.vin;
      vin_s_q <= vin_m_q;
      if (bus.ena) begin
        mode_q <= bus.mode;
        acc_out_q <= 32'(bus.sel) < CH ? acc_all[bus.sel] : '0;
      end
    end
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic up, dn, dir_q, dir_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic signed [CW-1:0] acc_q, acc_d;
    state_t st_q, st_d;
    assign up = vip_s_q[c] & ~vin_s_q[c];
    assign dn = ~vip_s_q[c] & vin_s_q[c];
    assign acc_all[c] = acc_q;
    assign bus.out[c] = st_q == HIGH;
    assign bus.out_oe[c] = st_q != UNDEF;
    // run-length filter, saturating integrator and decision, with mode-change clear winning
    always_comb begin
      dir_d = (up | dn) ? up : dir_q;
      cnt_d = (clr | mode_q | ~(up | dn)) ? '0 :
              (dir_q == up && cnt_q != '0) ? (cnt_q == FW'(FILT) ? cnt_q : cnt_q + 1'b1) : FW'(1);
      acc_d = clr ? '0 :
              (mode_q & up) ? (acc_q == AMAX ? acc_q : acc_q + 1'b1) :
              (mode_q & dn) ? (acc_q == AMIN ? acc_q : acc_q - 1'b1) : acc_q;
      st_d = clr ? UNDEF :
             !mode_q ? (cnt_d == FW'(FILT) ? (up ? HIGH : LOW) : st_q) :
             acc_d >= HYP ? HIGH : acc_d <= HYN ? LOW : st_q;
    end
    // channel state advances only while enabled
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        dir_q <= 1'b0;
        cnt_q <= '0;
        acc_q <= '0;
        st_q <= UNDEF;
      end else if (bus.ena) begin
        dir_q <= dir_d;
        cnt_q <= cnt_d;
        acc_q <= acc_d;
        st_q <= st_d;
      end
  end
endmodule
